fwd_hazard_unit: RTL

Parametrised forwarding and hazard unit for the RISC-8 pipeline, replacing the fixed two-source combinational forwarding logic. It keeps its own shadow pipeline of destination and write-enable information, advancing it under hold, flush and stall, and produces per-operand forward selects for the EX stage. It also generates the load-use stall for ID and counts stall cycles. It sits beside the ID/EX boundary and is driven from decode and pipeline control.

---
 rtl/fwd_hazard_unit.sv | 77 +++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: shadow-pipeline operand forwarding selects, load-use stall and stall counter
module fwd_hazard_unit #(
  parameter int ADDR_W   = 3,
  parameter int DEPTH    = 3,
  parameter int SEL_W    = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [ADDR_W-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              hold,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);
  logic [DEPTH-1:0]  v, wr;
  logic [ADDR_W-1:0] rd [DEPTH];
  // source and load fields are only ever consulted in s[0]; older slots keep just the producer info
  logic              ld0, u1, u2;
  logic [ADDR_W-1:0] r1, r2;
  logic              take;
  assign stall = id_valid && !flush && v[0] && ld0 && wr[0]
              && ((id_rs1_used && id_rs1 == rd[0]) || (id_rs2_used && id_rs2 == rd[0]))
              && !(ZERO_REG != 0 && rd[0] == '0);
  assign take = !flush && !stall;
  // scan oldest to youngest so the youngest matching producer overrides
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = DEPTH-1; k >= 1; k--) begin
      if (v[k] && wr[k] && v[0] && (ZERO_REG == 0 || rd[k] != '0)) begin
        if (u1 && rd[k] == r1) fwd_a = SEL_W'(k);
        if (u2 && rd[k] == r2) fwd_b = SEL_W'(k);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v           <= '0;
      wr          <= '0;
      ld0         <= 1'b0;
      u1          <= 1'b0;
      u2          <= 1'b0;
      r1          <= '0;
      r2          <= '0;
      stall_count <= '0;
      for (int k = 0; k < DEPTH; k++) rd[k] <= '0;
    end else begin
      if (stall && !hold && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (!hold) begin
        for (int k = 1; k < DEPTH; k++) begin
          v[k]  <= v[k-1];
          wr[k] <= wr[k-1];
          rd[k] <= rd[k-1];
        end
        v[0]  <= take && id_valid;
        wr[0] <= take && id_regwrite;
        ld0   <= take && id_is_load;
        u1    <= take && id_rs1_used;
        u2    <= take && id_rs2_used;
        rd[0] <= take ? id_rd : '0;
        r1    <= take ? id_rs1 : '0;
        r2    <= take ? id_rs2 : '0;
      end
    end
  end
endmodule
